// File: rtl/width_downsizer.sv
// ---------------------------------------------------------------------------
// width_downsizer
//
// Takes one IN_W-bit word on a valid/ready input stream and replays it as
// IN_W/OUT_W narrow slices on a valid/ready output stream. In truncate mode
// only the most-significant slice is emitted, which matches the older fixed
// "keep the upper half" behaviour.
//
// Parameters
//   IN_W      input word width, exact multiple of OUT_W
//   OUT_W     output slice width (>= 1)
//   MSB_FIRST 1: most-significant slice first, 0: least-significant first
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   MODE       0 = serialize all slices, 1 = truncate; sampled on accept
//   IN_VALID   INPT holds a valid word
//   IN_READY   block can take a word this cycle
//   INPT       wide input word
//   OUT_VALID  OTPT holds a valid slice
//   OUT_READY  consumer takes the slice this cycle
//   OTPT       current output slice
//   OUT_LAST   current slice is the final one of its word
//   BUSY       a word is held and not yet fully emitted
// ---------------------------------------------------------------------------
module width_downsizer #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  INPT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OTPT,
  output logic             OUT_LAST,
  output logic             BUSY
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  // Index of the most-significant slice (slices numbered from bit 0 up).
  localparam logic [CW-1:0] K_TOP = CW'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   k_q;
  logic [IN_W-1:0] hold_q;
  logic            mode_q;

  logic [OUT_W-1:0] slice_w [RATIO];
  logic [CW-1:0]    sel_idx;
  logic [CW-1:0]    last_k;
  logic             accept;
  logic             xfer;
  logic [CW-1:0]    k_d;

  // Cut the held word into its slices, numbered from the LSB upwards.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign slice_w[gi] = hold_q[gi*OUT_W +: OUT_W];
    end
  endgenerate

  // Truncate always shows the top slice; otherwise walk the slices in the
  // configured order. The mux only sees registered state, so OTPT never
  // depends combinationally on INPT.
  always_comb begin
    sel_idx = k_q;
    if (mode_q) begin
      sel_idx = K_TOP;
    end else if (MSB_FIRST) begin
      sel_idx = K_TOP - k_q;
    end
  end

  assign last_k    = mode_q ? '0 : K_TOP;
  assign OUT_VALID = (state_q == SEND);
  assign BUSY      = OUT_VALID;
  assign OTPT      = slice_w[sel_idx];
  assign OUT_LAST  = OUT_VALID & (k_q == last_k);

  // A new word can enter when nothing is held, or when the final slice is
  // leaving on this same edge (back-to-back without a bubble). This is a
  // combinational path from OUT_READY.
  assign IN_READY = ~RST & (~OUT_VALID | (OUT_READY & OUT_LAST));

  assign accept = IN_VALID & IN_READY;
  assign xfer   = OUT_VALID & OUT_READY;
  assign k_d    = k_q + CW'(1);

  // Accept takes priority: it can only coincide with a transfer of the
  // last slice, in which case the old word is finished anyway.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      hold_q  <= '0;
      mode_q  <= 1'b0;
    end else if (accept) begin
      state_q <= SEND;
      k_q     <= '0;
      hold_q  <= INPT;
      mode_q  <= MODE;
    end else if (xfer) begin
      if (OUT_LAST) begin
        state_q <= IDLE;
      end else begin
        k_q <= k_d;
      end
    end
  end

endmodule

// File: tb/tb_width_downsizer.sv
module tb_width_downsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        md   [2];
  logic        iv   [2];
  logic        ordy [2];
  logic [31:0] din  [2];

  logic        irdy0, ov0, last0, busy0;
  logic [15:0] ot0;
  logic        irdy1, ov1, last1, busy1;
  logic [7:0]  ot1;

  width_downsizer #(.IN_W(32), .OUT_W(16), .MSB_FIRST(1'b1)) u0 (
    .CLK(clk), .RST(rst), .MODE(md[0]), .IN_VALID(iv[0]), .IN_READY(irdy0),
    .INPT(din[0]), .OUT_VALID(ov0), .OUT_READY(ordy[0]), .OTPT(ot0),
    .OUT_LAST(last0), .BUSY(busy0)
  );

  width_downsizer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) u1 (
    .CLK(clk), .RST(rst), .MODE(md[1]), .IN_VALID(iv[1]), .IN_READY(irdy1),
    .INPT(din[1]), .OUT_VALID(ov1), .OUT_READY(ordy[1]), .OTPT(ot1),
    .OUT_LAST(last1), .BUSY(busy1)
  );

  // Reference: list of slices still owed for the word in flight.
  typedef struct packed {
    logic [15:0] s;
    logic        last;
  } ent_t;

  ent_t mq [2][4];
  int   mh [2];
  int   mn [2];
  bit   hz [2];
  bit   acc_f [2];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] slice_of(int i, logic [31:0] w, int j, logic m);
    int ow;
    int sh;
    logic [31:0] mask;
    ow = (i == 0) ? 16 : 8;
    if (m) sh = 32 - ow;
    else if (i == 0) sh = 32 - ow * (j + 1);
    else sh = ow * j;
    mask = (32'd1 << ow) - 32'd1;
    return 16'((w >> sh) & mask);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check both DUTs against the reference, advance the
  // reference across the edge.
  task automatic step();
    bit          ev [2];
    bit          er [2];
    bit          xf [2];
    logic        o_v, o_r, o_l, o_b;
    logic [15:0] o_d;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        o_v = ov0; o_r = irdy0; o_l = last0; o_b = busy0; o_d = ot0;
      end else begin
        o_v = ov1; o_r = irdy1; o_l = last1; o_b = busy1; o_d = {8'h00, ot1};
      end
      ev[i] = (mn[i] > 0);
      er[i] = !rst && (mn[i] == 0 || (ordy[i] && mn[i] == 1));
      chk($sformatf("u%0d_out_valid", i), {31'd0, o_v}, {31'd0, ev[i]});
      chk($sformatf("u%0d_busy", i), {31'd0, o_b}, {31'd0, ev[i]});
      chk($sformatf("u%0d_in_ready", i), {31'd0, o_r}, {31'd0, er[i]});
      chk($sformatf("u%0d_out_last", i), {31'd0, o_l},
          {31'd0, ev[i] ? mq[i][mh[i]].last : 1'b0});
      if (ev[i])
        chk($sformatf("u%0d_otpt", i), {16'd0, o_d}, {16'd0, mq[i][mh[i]].s});
      else if (hz[i])
        chk($sformatf("u%0d_otpt_reset", i), {16'd0, o_d}, 32'd0);
      acc_f[i] = iv[i] && er[i];
      xf[i]    = ev[i] && ordy[i];
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mn[i] = 0; mh[i] = 0; hz[i] = 1'b1; acc_f[i] = 1'b0;
      end else begin
        if (xf[i]) begin
          mh[i]++; mn[i]--;
        end
        if (acc_f[i]) begin
          int r;
          r = md[i] ? 1 : ((i == 0) ? 2 : 4);
          for (int j = 0; j < r; j++) begin
            mq[i][j].s    = slice_of(i, din[i], j, md[i]);
            mq[i][j].last = (j == r - 1);
          end
          mh[i] = 0; mn[i] = r; hz[i] = 1'b0;
        end
      end
    end
    #1;
  endtask

  logic [31:0] b2b [2];
  int idx;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      md[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b1; din[i] = '0;
      mn[i] = 0; mh[i] = 0; hz[i] = 1'b1; acc_f[i] = 1'b0;
    end
    @(posedge clk); #1;
    step();                       // reset values while RST=1
    rst = 1'b0;
    step();                       // IN_READY rises after reset

    // Serialize, MSB first: DEAD then BEEF
    din[0] = 32'hDEADBEEF; iv[0] = 1'b1; step();
    iv[0] = 1'b0;
    chk("deadbeef_first", {16'd0, ot0}, 32'h0000DEAD);
    repeat (3) step();

    // Truncate mode: only 0x1234
    md[0] = 1'b1; din[0] = 32'h12345678; iv[0] = 1'b1; step();
    iv[0] = 1'b0; md[0] = 1'b0;
    chk("truncate_slice", {16'd0, ot0}, 32'h00001234);
    repeat (2) step();

    // LSB first, 8-bit slices: D4 C3 B2 A1
    din[1] = 32'hA1B2C3D4; iv[1] = 1'b1; step();
    iv[1] = 1'b0;
    chk("lsb_first_slice", {24'd0, ot1}, 32'h000000D4);
    repeat (5) step();

    // Back-pressure on the first slice of CAFEF00D
    din[0] = 32'hCAFEF00D; iv[0] = 1'b1; step();
    iv[0] = 1'b0; ordy[0] = 1'b0;
    repeat (3) step();
    chk("stall_hold", {16'd0, ot0}, 32'h0000CAFE);
    ordy[0] = 1'b1;
    repeat (3) step();

    // Back-to-back words with no idle cycle
    b2b[0] = 32'h11112222; b2b[1] = 32'h33334444;
    idx = 0; din[0] = b2b[0]; iv[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (acc_f[0]) begin
        idx++;
        if (idx >= 2) iv[0] = 1'b0;
        else din[0] = b2b[idx];
      end
    end
    chk("b2b_both_taken", idx, 2);

    // Reset while the first slice of AAAABBBB is showing
    din[0] = 32'hAAAABBBB; iv[0] = 1'b1; step();
    iv[0] = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("reset_mid_word_valid", {31'd0, ov0}, 32'd0);
    repeat (2) step();

    // Randomized traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (acc_f[i]) iv[i] = 1'b0;
        if (!iv[i]) begin
          iv[i]  = ($urandom_range(0, 2) != 0);
          din[i] = $urandom;
        end
        md[i]   = 1'($urandom_range(0, 1));
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/width_downsizer.md
Name: width_downsizer

Overview:
- Parametrised, handshaked successor to the fixed 32-to-16 upper-half truncation.
- Accepts one IN_W-bit word and emits it as RATIO = IN_W/OUT_W narrow slices on a valid/ready stream.
- A truncate mode emits only the most-significant slice, which is the legacy behaviour.
- Sits between wide OCR datapath stages and narrower consumers, e.g. a 16-bit display or UART path.

Parameters:
- IN_W, 32, input word width; must be an exact multiple of OUT_W.
- OUT_W, 16, output slice width; minimum 1.
- MSB_FIRST, 1, 1 = first slice is INPT[IN_W-1 -: OUT_W]; 0 = first slice is INPT[OUT_W-1:0].

Ports:
- CLK  input  1  single system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- MODE  input  1  0 = serialize all RATIO slices; 1 = truncate (emit top slice only); sampled at word acceptance.
- IN_VALID  input  1  INPT holds a valid word.
- IN_READY  output  1  block can accept a word this cycle.
- INPT  input  IN_W  wide input word.
- OUT_VALID  output  1  OTPT holds a valid slice.
- OUT_READY  input  1  consumer accepts the slice this cycle.
- OTPT  output  OUT_W  current output slice.
- OUT_LAST  output  1  current slice is the final slice of its word.
- BUSY  output  1  a word is held and not fully emitted.

Behaviour:
- Reset values (any cycle RST=1):
  - OUT_VALID=0, OUT_LAST=0, OTPT=0, BUSY=0; slice counter=0; holding register=0; held mode=0.
  - IN_READY=0 while RST=1; IN_READY=1 from the first cycle after RST falls.
- States:
  - IDLE (OUT_VALID=0).
  - SEND (OUT_VALID=1, counter k = 0..R-1).
  - R = RATIO in serialize mode, R = 1 in truncate mode.
- Accept:
  - Occurs when IN_VALID & IN_READY at an edge.
  - Loads the holding register from INPT, latches MODE, sets k=0, enters SEND.
  - OUT_VALID=1 from the next cycle, so latency is 1 cycle from accept to first slice.
- Slice select:
  - MSB_FIRST=1: OTPT = hold[IN_W-1-k*OUT_W -: OUT_W].
  - MSB_FIRST=0: OTPT = hold[k*OUT_W +: OUT_W].
  - OTPT is driven from registered state only; there is no combinational path from INPT.
  - In truncate mode the single slice is always hold[IN_W-1 -: OUT_W], regardless of MSB_FIRST.
- OUT_LAST = OUT_VALID & (k == R-1).
- Transfer:
  - Occurs when OUT_VALID & OUT_READY at an edge.
  - If not last: k increments.
  - If last and a new word is accepted in the same edge: reload, k=0, stay in SEND (back-to-back, no bubble).
  - If last with no new word: go to IDLE, OUT_VALID=0.
- IN_READY:
  - IN_READY = ~RST & (~OUT_VALID | (OUT_READY & OUT_LAST)).
  - This is a combinational path from OUT_READY to IN_READY.
  - Full throughput is one word per R cycles.
- Stall: while OUT_VALID=1 and OUT_READY=0, OTPT, OUT_LAST and k hold stable.
- MODE changes while BUSY do not affect the word in flight.
- BUSY = OUT_VALID.
- RATIO=1 (IN_W==OUT_W): every slice is last; the block behaves as a 1-deep registered pipe.
- Reset asserted mid-word: remaining slices are discarded; no partial output after reset.
- IN_VALID while IN_READY=0: the word is not taken; the source must hold it.

Test Plan:
- IN_W=32, OUT_W=16, MSB_FIRST=1, MODE=0, OUT_READY=1; send 0xDEADBEEF -> OTPT=0xDEAD (OUT_LAST=0) then 0xBEEF (OUT_LAST=1) on consecutive cycles, first slice 1 cycle after accept.
- Same configuration with MODE=1; send 0x12345678 -> single slice 0x1234 with OUT_LAST=1, then IDLE; matches the legacy truncation.
- MSB_FIRST=0, IN_W=32, OUT_W=8, MODE=0; send 0xA1B2C3D4 -> slices 0xD4, 0xC3, 0xB2, 0xA1, with OUT_LAST only on 0xA1.
- Back-pressure: OUT_READY=0 for 3 cycles after the first slice of 0xCAFEF00D -> OTPT holds 0xCAFE, IN_READY=0; release -> 0xF00D, no duplication or loss.
- Back-to-back: words 0x11112222 and 0x33334444 offered continuously, OUT_READY=1 -> stream 0x1111, 0x2222, 0x3333, 0x4444 with no idle cycle; IN_READY pulses with each last slice.
- Reset mid-word: RST=1 for one cycle after 0xAAAA of 0xAAAABBBB -> OUT_VALID=0, OTPT=0, 0xBBBB never appears; IN_READY=1 the next cycle.
